// File: rtl/spi_frame_pkg.sv
// Shared definitions for the LED-frame SPI link (master and slave parsing).
// Optional checksum byte controlled by macro SPI_FRAME_CHECKSUM_EN.
package spi_frame_pkg;

  localparam logic [7:0] SPI_START0 = 8'h55;
  localparam logic [7:0] SPI_START1 = 8'h5B;
  localparam logic [7:0] SPI_STOP   = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LOAD,
    FETCH,
    SHIFT,
    GAP,
    CS_HOLD,
    DONE
  } spi_master_state_t;

  // Total bytes on the wire for one frame: two start bytes, payload,
  // optional XOR checksum, stop byte.
  function automatic int frame_bytes(input int leds);
`ifdef SPI_FRAME_CHECKSUM_EN
    return leds * 3 + 4;
`else
    return leds * 3 + 3;
`endif
  endfunction

endpackage

// File: rtl/spi_frame_if.sv
// Bundle of the frame-request handshake, frame-memory read port and SPI pins.
interface spi_frame_if #(
  parameter int ADDR_WIDTH = 7
);

  logic                  i_start;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic [7:0]            i_rd_data;
  logic                  o_sclk;
  logic                  o_cs;
  logic                  o_mosi;
  logic                  o_busy;
  logic                  o_frame_done;

  modport master (
    input  i_start, i_rd_data,
    output o_rd_addr, o_sclk, o_cs, o_mosi, o_busy, o_frame_done
  );

  modport slave (
    output i_start, i_rd_data,
    input  o_rd_addr, o_sclk, o_cs, o_mosi, o_busy, o_frame_done
  );

endinterface

// File: rtl/spi_byte_shifter.sv
// Mode-0 byte serializer: CLK_DIV divider, bit counter and MSB-first shift
// register. A load starts a byte with SCLK low; o_byte_done marks the cycle
// whose edge returns SCLK low after the eighth high phase.
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_byte_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sclk_q, sclk_d;
  logic             active_q, active_d;
  logic             byte_done;

  // Half-period divider; data advances only when SCLK falls.
  always_comb begin
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    sclk_d    = sclk_q;
    active_d  = active_q;
    byte_done = 1'b0;
    if (i_load) begin
      shreg_d  = i_byte;
      div_d    = '0;
      bit_d    = '0;
      sclk_d   = 1'b0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          if (bit_q == 3'd7) begin
            active_d  = 1'b0;
            byte_done = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Shifter state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
    end
  end

  assign o_sclk      = sclk_q;
  assign o_mosi      = shreg_q[7];
  assign o_byte_done = byte_done;

endmodule

// File: rtl/spi_frame_master.sv
// LED frame SPI master: 0x55 0x5B, LEDS*3 payload bytes from a 1-cycle
// synchronous frame memory, optional XOR checksum, then 0xAA.
// Optional checksum byte controlled by macro SPI_FRAME_CHECKSUM_EN.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int LEDS       = 30,
  parameter int ADDR_WIDTH = $clog2(LEDS * 3),
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  spi_frame_if.master bus
);

  localparam int PAYLOAD = LEDS * 3;
  localparam int NBYTES  = frame_bytes(LEDS);
  localparam int IDX_W   = $clog2(NBYTES + 1);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  spi_master_state_t     state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cs_q, cs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  is_payload, is_last, shift_load, byte_done;
  logic                  sclk, mosi;
  logic [7:0]            fetch_byte;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  // Classify the current byte index and pick the byte to serialize.
  always_comb begin
    is_payload = (idx_q >= IDX_W'(2)) && (idx_q < IDX_W'(PAYLOAD + 2));
    is_last    = (idx_q == IDX_W'(NBYTES - 1));
    fetch_byte = SPI_STOP;
    if (idx_q == IDX_W'(0)) begin
      fetch_byte = SPI_START0;
    end else if (idx_q == IDX_W'(1)) begin
      fetch_byte = SPI_START1;
    end else if (is_payload) begin
      fetch_byte = bus.i_rd_data;
`ifdef SPI_FRAME_CHECKSUM_EN
    end else if (idx_q == IDX_W'(PAYLOAD + 2)) begin
      fetch_byte = xor_q;
`endif
    end
  end

  // Frame sequencer; the read address is driven during LOAD so the memory
  // data lands in FETCH, and holds its last value otherwise.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_addr_d  = rd_addr_q;
    shift_load = 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = CS_SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      CS_SETUP: begin
`ifdef SPI_FRAME_CHECKSUM_EN
        xor_d = '0;
`endif
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD: begin
        if (is_payload) begin
          rd_addr_d = ADDR_WIDTH'(idx_q - IDX_W'(2));
        end
        state_d = FETCH;
      end
      FETCH: begin
        shift_load = 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
        if (is_payload) begin
          xor_d = xor_q ^ bus.i_rd_data;
        end
`endif
        state_d = SHIFT;
      end
      SHIFT: begin
        if (byte_done) begin
          cnt_d = '0;
          if (is_last) begin
            state_d = CS_HOLD;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = (GAP_CYCLES > 0) ? GAP : LOAD;
          end
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CS_HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
`ifdef SPI_FRAME_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
`ifdef SPI_FRAME_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  spi_byte_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (shift_load),
    .i_byte     (fetch_byte),
    .o_sclk     (sclk),
    .o_mosi     (mosi),
    .o_byte_done(byte_done)
  );

  assign bus.o_rd_addr    = rd_addr_d;
  assign bus.o_sclk       = sclk;
  assign bus.o_mosi       = mosi;
  assign bus.o_cs         = cs_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
SPI mode-0 master that transmits one LED frame per request: start bytes 0x55 0x5B, then LEDS*3 payload bytes, then stop byte 0xAA. It is the sending end of the LED link whose slave stores frames into the double buffer. Payload bytes are fetched from a synchronous-read frame memory (1-cycle read latency). It is used on a controller board and in loopback benches against the spi_slave receive path.

Parameters:
LEDS, 30, number of pixels; payload = LEDS*3 bytes
ADDR_WIDTH, $clog2(LEDS*3), frame memory address width
CLK_DIV, 4, i_clk cycles per SCLK half-period (>=1); 50 MHz/8 = 6.25 MHz SCLK
GAP_CYCLES, 0, extra idle i_clk cycles between bytes, with CS held low and SCLK low

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  1-cycle frame request; ignored while o_busy=1
o_rd_addr  out  ADDR_WIDTH  frame memory read address
i_rd_data  in  8  memory data, valid the cycle after o_rd_addr is presented
o_sclk  out  1  SPI clock, idles low
o_cs  out  1  chip select, active-low
o_mosi  out  1  serial data, MSB first
o_busy  out  1  high from the cycle after i_start is accepted until the cycle o_frame_done pulses (inclusive)
o_frame_done  out  1  1-cycle pulse after CS deasserts

Behaviour:
- Interface: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset values: o_sclk=0, o_cs=1, o_mosi=0, o_busy=0, o_frame_done=0, o_rd_addr=0, state=IDLE, byte index=0.
- Reset mid-frame: the next edge forces the reset values, with no trailing SCLK edge. The frame is abandoned.
- Byte sequence: N = LEDS*3+3 bytes.
  - idx0 = 0x55, idx1 = 0x5B.
  - idx 2..LEDS*3+1 = mem[idx-2].
  - last = 0xAA.
- States:
  - IDLE: on i_start -> CS_SETUP. o_cs drops to 0 on this edge.
  - CS_SETUP: lasts CLK_DIV cycles -> LOAD.
  - LOAD (1 cycle): drive o_rd_addr = idx-2 for payload bytes; for constant bytes the address is don't-care -> FETCH.
  - FETCH (1 cycle): latch the byte (constant or i_rd_data) into an 8-bit shift register; o_mosi = bit7 -> SHIFT.
  - SHIFT: 8 bits. Per bit, SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles. The slave samples on the rising edge. MOSI changes only on the falling edge, i.e. the first cycle of the next low phase. The byte ends with SCLK returning low. Exit: if last byte -> CS_HOLD; else if GAP_CYCLES>0 -> GAP; else -> LOAD.
  - GAP: GAP_CYCLES cycles -> LOAD.
  - CS_HOLD: CLK_DIV cycles with SCLK low, then o_cs=1 -> DONE.
  - DONE (1 cycle): o_frame_done=1 -> IDLE. o_busy drops the following cycle.
- CS low duration = 2*CLK_DIV + N*(2+16*CLK_DIV) + (N-1)*GAP_CYCLES cycles.
- Counters:
  - byte index width = $clog2(N+1); it never wraps within a frame.
  - divider counter width = $clog2(CLK_DIV+1).
- i_start during busy, or coincident with the DONE cycle: dropped, no queuing.
- o_rd_addr holds its last value outside LOAD. The memory must not change during a frame; the double-buffer read side guarantees this.

Optional Feature:
Macro SPI_FRAME_CHECKSUM_EN.
- Defined: an extra byte equal to the XOR of all LEDS*3 payload bytes is sent after the payload and before 0xAA, so N = LEDS*3+4. The XOR accumulator clears in CS_SETUP and updates in FETCH for payload bytes only.
- Undefined: no checksum byte; N = LEDS*3+3; no accumulator logic.
- The receiver must be built with the matching option.

Decomposition:
- Package spi_frame_pkg:
  - SPI_START0=8'h55, SPI_START1=8'h5B, SPI_STOP=8'hAA
  - spi_master_state_t enum (IDLE, CS_SETUP, LOAD, FETCH, SHIFT, GAP, CS_HOLD, DONE)
  - shared by spi_slave frame-parsing logic.
- One sub-module, spi_byte_shifter:
  - contains the CLK_DIV divider, 3-bit bit counter and shift register.
  - inputs: i_load, i_byte. Outputs: o_sclk, o_mosi, o_byte_done (1-cycle).

Test Plan:
1. LEDS=2, CLK_DIV=2, GAP=0, mem={01,02,03,04,05,06}, pulse i_start -> SPI monitor decodes 55 5B 01 02 03 04 05 06 AA; CS low exactly 4+9*34=310 cycles; o_frame_done 1 cycle after CS rises.
2. Mode-0 timing check: MOSI stable for the whole SCLK-high phase; SCLK=0 at CS fall and at CS rise; exactly 72 rising edges per frame.
3. i_start pulsed again mid-frame and on the DONE cycle -> ignored; only one frame sent; o_busy stays high continuously.
4. Assert i_rst during payload byte 3 -> next cycle o_cs=1, o_sclk=0, o_busy=0; a new i_start afterwards sends a complete, correct frame.
5. Loopback into spi_slave with LEDS=30, CLK_DIV=4, GAP_CYCLES=3, random payload -> double buffer contents match mem; frame-done seen once.
6. SPI_FRAME_CHECKSUM_EN, LEDS=2, payload {01,02,04,08,10,20} -> byte stream ends ... 20 3F AA; N=10.
